// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types for the FFT frame sequencer and the output tracker it shares with the IFFT path.
package fft_frame_sequencer_pkg;

    localparam int DATA_W      = 32;
    localparam int FRAME_IDX_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] i;
    } complex_product_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } fft_seq_state_e;

endpackage

// File: rtl/fft_seq_out_tracker.sv
// Output-side bookkeeping: counts N/2 pairs per frame, tags last/frame index, tracks frames in flight.
module fft_seq_out_tracker
    import fft_frame_sequencer_pkg::*;
#(
    parameter int N            = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               dc_out_valid,
    input  complex_product_t                   dc_y0,
    input  complex_product_t                   dc_y1,
    input  logic                               frame_done,
    input  logic                               abandon,
    output logic                               out_valid,
    output complex_product_t                   out_y0,
    output complex_product_t                   out_y1,
    output logic                               out_last,
    output logic [FRAME_IDX_W-1:0]             out_frame,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight
);

    localparam int HALF = N / 2;
    localparam int CW   = $clog2(HALF);

    logic [CW-1:0]          out_cnt;
    logic [FRAME_IDX_W-1:0] frame_q;
    logic                   take;
    logic                   pair_last;

    // Chain output arriving with nothing in flight is stale and dropped.
    assign take      = dc_out_valid && (inflight != '0);
    assign pair_last = take && (out_cnt == CW'(HALF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_y0    <= '0;
            out_y1    <= '0;
            out_frame <= '0;
            frame_q   <= '0;
            out_cnt   <= '0;
            inflight  <= '0;
        end else begin
            out_valid <= take;
            out_last  <= pair_last;
            if (take) begin
                out_y0    <= dc_y0;
                out_y1    <= dc_y1;
                out_frame <= frame_q;
            end
            if (pair_last) begin
                frame_q <= frame_q + 1'b1;
            end

            if (abandon) begin
                out_cnt <= '0;
            end else if (take) begin
                out_cnt <= pair_last ? '0 : out_cnt + 1'b1;
            end

            if (abandon) begin
                inflight <= '0;
            end else if (frame_done && !pair_last) begin
                inflight <= inflight + 1'b1;
            end else if (!frame_done && pair_last) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the delay-commutator chain: feeds x0/x1 every cycle, flushes, tags outputs.
//  state    | meaning
//  ST_IDLE  | chain fed zeros, waiting for enable + data + inflight headroom
//  ST_LOAD  | consuming N/2 upstream pairs, one per cycle, no stall
//  ST_FLUSH | chain fed zeros until all in-flight frames drain or the timeout trips
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int N             = 16,
    parameter int MAX_INFLIGHT  = 2,
    parameter int FLUSH_TIMEOUT = 2 * N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  complex_product_t       in_x0,
    input  complex_product_t       in_x1,
    output complex_product_t       dc_x0,
    output complex_product_t       dc_x1,
    input  complex_product_t       dc_y0,
    input  complex_product_t       dc_y1,
    input  logic                   dc_out_valid,
    output logic                   out_valid,
    output complex_product_t       out_y0,
    output complex_product_t       out_y1,
    output logic                   out_last,
    output logic [FRAME_IDX_W-1:0] out_frame,
    output logic                   busy,
    output logic                   err_underrun,
    output logic                   err_timeout
);

    localparam int HALF = N / 2;
    localparam int CW   = $clog2(HALF);
    localparam int IW   = $clog2(MAX_INFLIGHT + 1);
    localparam int TW   = $clog2(FLUSH_TIMEOUT + 1);

    if (DATA_WIDTH != DATA_W) begin : g_width_check
        $error("DATA_WIDTH must match the complex_product_t component width");
    end

    fft_seq_state_e state, state_nx;
    logic [CW-1:0]  in_cnt;
    logic [TW-1:0]  timeout;
    logic [IW-1:0]  inflight;
    logic           frame_done;
    logic           abandon;
    logic           can_start;
    logic           load_last;
    logic           timeout_hit;

    assign can_start   = enable && in_valid && (int'(inflight) < MAX_INFLIGHT);
    assign load_last   = (in_cnt == CW'(HALF - 1));
    assign timeout_hit = (timeout == TW'(FLUSH_TIMEOUT - 1)) && !dc_out_valid;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        abandon    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (can_start) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (load_last) begin
                    frame_done = 1'b1;
                    if (enable && in_valid && (int'(inflight) + 1 < MAX_INFLIGHT)) begin
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (timeout_hit) begin
                    abandon  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (inflight == '0) begin
                    state_nx = ST_IDLE;
                end else if (can_start) begin
                    state_nx = ST_LOAD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A missing pair in LOAD still occupies its slot so the chain's timing stays intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_x0        <= '0;
            dc_x1        <= '0;
            in_cnt       <= '0;
            timeout      <= '0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (state == ST_LOAD && in_valid) begin
                dc_x0 <= in_x0;
                dc_x1 <= in_x1;
            end else begin
                dc_x0 <= '0;
                dc_x1 <= '0;
            end
            in_cnt <= (state == ST_LOAD && !load_last) ? in_cnt + 1'b1 : '0;
            if (state == ST_FLUSH && !abandon && !dc_out_valid) begin
                timeout <= timeout + 1'b1;
            end else begin
                timeout <= '0;
            end
            if (state == ST_LOAD && !in_valid) begin
                err_underrun <= 1'b1;
            end
            if (abandon) begin
                err_timeout <= 1'b1;
            end
        end
    end

    fft_seq_out_tracker #(
        .N            (N),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_out_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .dc_out_valid (dc_out_valid),
        .dc_y0        (dc_y0),
        .dc_y1        (dc_y1),
        .frame_done   (frame_done),
        .abandon      (abandon),
        .out_valid    (out_valid),
        .out_y0       (out_y0),
        .out_y1       (out_y1),
        .out_last     (out_last),
        .out_frame    (out_frame),
        .inflight     (inflight)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with a behavioural fixed-latency chain standing in for dc_top.
module tb_fft_frame_sequencer;
    import fft_frame_sequencer_pkg::*;

    localparam int N    = 16;
    localparam int HALF = N / 2;
    localparam int MAXF = 2;
    localparam int TMO  = 2 * N;
    localparam int LAT  = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready, dc_out_valid, out_valid, out_last, busy, err_underrun, err_timeout;
    complex_product_t in_x0 = '0, in_x1 = '0;
    complex_product_t dc_x0, dc_x1, dc_y0, dc_y1, out_y0, out_y1;
    logic [FRAME_IDX_W-1:0] out_frame;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .DATA_WIDTH(32), .N(N), .MAX_INFLIGHT(MAXF), .FLUSH_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .dc_x0(dc_x0), .dc_x1(dc_x1),
        .dc_y0(dc_y0), .dc_y1(dc_y1), .dc_out_valid(dc_out_valid),
        .out_valid(out_valid), .out_y0(out_y0), .out_y1(out_y1), .out_last(out_last),
        .out_frame(out_frame), .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    // Chain model: fixed latency, a pair is valid if it was sent during a LOAD cycle; y0/y1 swapped.
    typedef struct packed { logic v; complex_product_t a; complex_product_t b; } stage_t;
    stage_t pipe [LAT];
    logic   ld_q;
    logic   mute = 1'b0;
    logic   inject = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            ld_q <= 1'b0;
        end else begin
            ld_q    <= in_ready;
            pipe[0] <= {ld_q, dc_x0, dc_x1};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dc_out_valid = (pipe[LAT-1].v && !mute) || inject;
    assign dc_y0 = pipe[LAT-1].b;
    assign dc_y1 = pipe[LAT-1].a;

    typedef struct packed { complex_product_t a; complex_product_t b; } pair_t;
    typedef struct packed {
        complex_product_t y0; complex_product_t y1; logic last; logic [7:0] frame;
    } exp_t;

    pair_t dcx_q[$];
    exp_t  out_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    model_pairs = 0;
    int    model_frames = 0;
    int    out_seen = 0;
    int    last_seen = 0;
    int    last_mark_cyc = -1;
    int    cons_cyc [32];
    bit    seq_data = 1'b0;
    bit    prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference: the k-th consumed pair (zeroed if not valid) is the k-th output, frame k/8, last on k%8==7.
    function automatic void push_pair(complex_product_t a, complex_product_t b, logic v);
        pair_t p;
        exp_t  e;
        p.a = v ? a : '0;
        p.b = v ? b : '0;
        dcx_q.push_back(p);
        e.y0    = p.b;
        e.y1    = p.a;
        e.last  = ((model_pairs % HALF) == HALF - 1);
        e.frame = 8'(model_frames);
        out_q.push_back(e);
        model_pairs++;
        if (e.last) model_frames++;
    endfunction

    always @(negedge clk) begin
        logic [63:0] t0, t1;
        pair_t p;
        exp_t  e;
        if (!rst_n) begin
            prev_ready = 1'b0;
        end else begin
            if (prev_ready) begin
                if (dcx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dcx_extra actual=%h required=none", {dc_x0, dc_x1});
                end else begin
                    p = dcx_q.pop_front();
                    chk("dcx_x0", dc_x0, p.a);
                    chk("dcx_x1", dc_x1, p.b);
                end
            end else begin
                t0 = dc_x0;
                t1 = dc_x1;
                chk("dcx_zero", t0 | t1, 64'd0);
            end
            prev_ready = in_ready;
            if (out_valid) begin
                out_seen++;
                if (out_last) last_seen++;
                if (out_last && last_mark_cyc < 0) last_mark_cyc = cyc;
                if (out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_extra actual=%h required=none", {out_y0, out_y1});
                end else begin
                    e = out_q.pop_front();
                    chk("out_y0", out_y0, e.y0);
                    chk("out_y1", out_y1, e.y1);
                    chk("out_tags", {55'd0, out_last, out_frame}, {55'd0, e.last, e.frame});
                end
            end
        end
    end

    function automatic complex_product_t mk(int k, int off);
        complex_product_t c;
        if (seq_data) begin
            c.r = DATA_W'(k % HALF + off);
            c.i = '0;
        end else begin
            c.r = $urandom();
            c.i = $urandom();
        end
        return c;
    endfunction

    function automatic logic pick_valid(int k, int drop_k);
        if (drop_k == -2) return ((k % HALF) == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
        return (k % HALF) != drop_k;
    endfunction

    task automatic drive(int n, int drop_k, int abort_k);
        int k = 0;
        int guard = 0;
        complex_product_t a, b;
        logic v;
        logic [63:0] t;
        a = mk(0, 0); b = mk(0, HALF); v = pick_valid(0, drop_k);
        while (k < n) begin
            @(negedge clk);
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                chk("reset_mid_ctrl", {50'd0, in_ready, out_valid, out_last, busy, err_underrun,
                                       err_timeout, out_frame}, 64'd0);
                t = dc_x0 | dc_x1 | out_y0 | out_y1;
                chk("reset_mid_data", t, 64'd0);
                dcx_q.delete(); out_q.delete();
                model_pairs = 0; model_frames = 0;
                in_valid = 1'b0; enable = 1'b1;
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            in_x0 = a; in_x1 = b; in_valid = v;
            enable = (k != n - 1);
            if (in_ready) begin
                push_pair(a, b, v);
                if (k < 32) cons_cyc[k] = cyc;
                k++;
                a = mk(k, 0); b = mk(k, HALF); v = pick_valid(k, drop_k);
                guard = 0;
            end else begin
                guard++;
                if (guard > 400) begin
                    checks++; errors++;
                    $display("FAIL drive_stall actual=%0d required=%0d pairs", k, n);
                    break;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic drain(string name);
        int g = 0;
        while ((out_q.size() != 0 || busy) && g < 600) begin
            @(negedge clk);
            g++;
        end
        chk(name, 64'(g < 600), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int o0, l0, fl, bad;
        bit early;
        logic [63:0] t;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {50'd0, in_ready, out_valid, out_last, busy, err_underrun,
                           err_timeout, out_frame}, 64'd0);
        t = dc_x0 | dc_x1 | out_y0 | out_y1;
        chk("reset_data", t, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        enable = 1'b1;

        // single frame, sequential data
        seq_data = 1'b1;
        o0 = out_seen; l0 = last_seen;
        drive(HALF, -1, -1);
        drain("drain_single");
        chk("single_outs", 64'(out_seen - o0), 64'(HALF));
        chk("single_lasts", 64'(last_seen - l0), 64'd1);
        chk("single_errs", {62'd0, err_underrun, err_timeout}, 64'd0);
        chk("single_busy", 64'(busy), 64'd0);
        seq_data = 1'b0;

        // three frames offered back to back; third must wait for first out_last
        o0 = out_seen; l0 = last_seen; last_mark_cyc = -1;
        drive(3 * HALF, -1, -1);
        drain("drain_b2b");
        chk("b2b_no_gap", 64'(cons_cyc[2*HALF-1] - cons_cyc[0]), 64'(2*HALF - 1));
        chk("b2b_refused", 64'(cons_cyc[2*HALF] > last_mark_cyc), 64'd1);
        chk("b2b_outs", 64'(out_seen - o0), 64'(3 * HALF));
        chk("b2b_lasts", 64'(last_seen - l0), 64'd3);

        // enable low holds IDLE
        enable = 1'b0; in_valid = 1'b1; in_x0 = mk(0, 0); in_x1 = mk(0, 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            t = dc_x0 | dc_x1;
            if (in_ready || busy || t != 0) bad++;
        end
        chk("enable_low_idle", 64'(bad), 64'd0);
        in_valid = 1'b0; enable = 1'b1;

        // underrun on pair 3
        o0 = out_seen;
        drive(HALF, 3, -1);
        drain("drain_underrun");
        chk("underrun_outs", 64'(out_seen - o0), 64'(HALF));
        chk("underrun_flag", 64'(err_underrun), 64'd1);

        // chain silent -> timeout after TMO flush cycles
        mute = 1'b1;
        drive(HALF, -1, -1);
        fl = 0; early = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (!busy) break;
            if (!in_ready) begin
                fl++;
                if (err_timeout) early = 1'b1;
            end
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(fl), 64'(TMO));
        chk("timeout_not_early", 64'(early), 64'd0);
        chk("timeout_flag", {62'd0, err_timeout, busy}, 64'd2);
        chk("underrun_sticky", 64'(err_underrun), 64'd1);
        model_frames -= out_q.size() / HALF;
        model_pairs  -= out_q.size();
        out_q.delete();
        mute = 1'b0;

        // stray chain valid with nothing in flight is ignored
        o0 = out_seen;
        repeat (3) @(negedge clk);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_valid_ignored", 64'(out_seen - o0), 64'd0);

        // reset on pair 5, then a clean restart
        drive(HALF, -1, 5);
        o0 = out_seen; l0 = last_seen;
        drive(HALF, -1, -1);
        drain("drain_restart");
        chk("restart_outs", 64'(out_seen - o0), 64'(HALF));
        chk("restart_lasts", 64'(last_seen - l0), 64'd1);
        chk("restart_errs", {62'd0, err_underrun, err_timeout}, 64'd0);

        // randomized frames, gaps and drops
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            drive(HALF * (1 + int'($urandom_range(0, 1))), -2, -1);
        end
        drain("drain_random");
        chk("queues_empty", 64'(out_q.size() + dcx_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
